// File: rtl/pulse_sync_toggle_rx.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_toggle_rx
// Description : Receive end of a 2-phase toggle pulse crossing. It lives in
//               the destination (clk_o) domain. It synchronises the incoming
//               source toggle and turns every level change into one event.
//               Events wait in a saturating pending counter, are handed out
//               over a valid/ready interface, and each consumed event is
//               returned to the source as a toggle of ack_tgle_o.
// Ports       : clk_o        destination clock (the only clock of this block)
//               rstn_i       asynchronous active-low reset
//               tgle_i       source toggle, asynchronous to clk_o
//               evt_pulse_o  one-cycle pulse per detected transition
//               evt_valid_o  pending counter is non-zero
//               evt_ready_i  consumer accepts one event when valid
//               evt_cnt_o    pending event count
//               ack_tgle_o   toggles once per consumed event
//               ovf_o        sticky: an event arrived while the counter was full
//               ovf_clr_i    synchronous clear of ovf_o
//               evt_total_o  running count of detected events (statistics)
// Options     : PULSE_SYNC_RX_STAT_EN - when defined, evt_total_o counts
//               every detected event (dropped ones included) and wraps at
//               16 bits; when undefined it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_toggle_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk_o,
    input  logic             rstn_i,
    input  logic             tgle_i,
    output logic             evt_pulse_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             ack_tgle_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    output logic [15:0]      evt_total_o
);

    // A single-flop synchroniser is not safe against metastability.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pulse_sync_toggle_rx: SYNC_STAGES must be at least 2");
    end

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_pulse;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_valid;
    logic                   r_ack;
    logic                   r_ovf;

    logic                   w_s;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_ovf_set;

    assign w_s    = r_sync[SYNC_STAGES-1];
    // The push is taken on the same edge that registers evt_pulse_o, so the
    // counter and the pulse output move together.
    assign w_push = w_s ^ r_hist;
    // Valid is registered, so ready never reaches valid combinationally and a
    // pop can only happen with a non-zero count (no underflow).
    assign w_pop  = r_valid & evt_ready_i;
    assign w_full = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_set = 1'b0;
        if (w_push && !w_pop) begin
            if (!w_full) begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end else begin
                w_ovf_set = 1'b1;        // event is dropped
            end
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
        // push and pop together leave the count unchanged, even when full
    end

    always_ff @(posedge clk_o or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], tgle_i};
            r_hist  <= w_s;
            r_pulse <= w_push;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            if (w_pop) begin
                r_ack <= ~r_ack;
            end
            // A new overflow wins over a clear in the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef PULSE_SYNC_RX_STAT_EN
    logic [15:0] r_total;

    // Counts every detected event, dropped ones included; wraps naturally.
    always_ff @(posedge clk_o or negedge rstn_i) begin
        if (!rstn_i) begin
            r_total <= 16'h0000;
        end else if (w_push) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign evt_total_o = r_total;
`else
    assign evt_total_o = 16'h0000;
`endif

    assign evt_pulse_o = r_pulse;
    assign evt_valid_o = r_valid;
    assign evt_cnt_o   = r_cnt;
    assign ack_tgle_o  = r_ack;
    assign ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_toggle_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sync_toggle_rx
// Description : Self-checking bench for pulse_sync_toggle_rx. A behavioural
//               model (sample history of tgle_i plus integer bookkeeping)
//               predicts every output; a compare process checks the DUT on
//               each falling clock edge, and directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_toggle_rx;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk_o;
    logic             rstn_i;
    logic             tgle_i;
    logic             evt_pulse_o;
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [CNT_W-1:0] evt_cnt_o;
    logic             ack_tgle_o;
    logic             ovf_o;
    logic             ovf_clr_i;
    logic [15:0]      evt_total_o;

    int n_checks = 0;
    int n_errors = 0;

    pulse_sync_toggle_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_o       (clk_o),
        .rstn_i      (rstn_i),
        .tgle_i      (tgle_i),
        .evt_pulse_o (evt_pulse_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_cnt_o   (evt_cnt_o),
        .ack_tgle_o  (ack_tgle_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i),
        .evt_total_o (evt_total_o)
    );

    initial begin
        clk_o = 1'b0;
        forever #5 clk_o = ~clk_o;
    end

    // ------------------------------------------------------------------
    // Model: an event is seen SYNC_STAGES edges after tgle_i is sampled at
    // a new level. m_samp[0] holds the newest clock-edge sample of tgle_i.
    // ------------------------------------------------------------------
    logic m_samp [0:SYNC_STAGES];
    int   m_cnt;
    logic m_pulse;
    logic m_ack;
    logic m_ovf;
    int   m_total;
    logic m_push;
    logic m_pop;

    assign m_push = m_samp[SYNC_STAGES-1] ^ m_samp[SYNC_STAGES];
    assign m_pop  = (m_cnt != 0) && evt_ready_i;

    always @(posedge clk_o or negedge rstn_i) begin : model
        if (!rstn_i) begin
            for (int i = 0; i <= SYNC_STAGES; i++) m_samp[i] <= 1'b0;
            m_cnt   <= 0;
            m_pulse <= 1'b0;
            m_ack   <= 1'b0;
            m_ovf   <= 1'b0;
            m_total <= 0;
        end else begin
            m_samp[0] <= tgle_i;
            for (int i = 1; i <= SYNC_STAGES; i++) m_samp[i] <= m_samp[i-1];
            m_pulse <= m_push;
            if (m_push && !m_pop) begin
                if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
            end else if (!m_push && m_pop) begin
                m_cnt <= m_cnt - 1;
            end
            if (m_push && !m_pop && m_cnt == CMAX) m_ovf <= 1'b1;
            else if (ovf_clr_i)                    m_ovf <= 1'b0;
            if (m_pop) m_ack <= ~m_ack;
`ifdef PULSE_SYNC_RX_STAT_EN
            if (m_push) m_total <= (m_total + 1) & 32'hFFFF;
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_o) begin : compare
        chk("pulse", int'(evt_pulse_o), int'(m_pulse));
        chk("valid", int'(evt_valid_o), (m_cnt != 0) ? 1 : 0);
        chk("cnt",   int'(evt_cnt_o),   m_cnt);
        chk("ack",   int'(ack_tgle_o),  int'(m_ack));
        chk("ovf",   int'(ovf_o),       int'(m_ovf));
        chk("total", int'(evt_total_o), m_total);
    end

    // Inputs change 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_o);
        #1;
    endtask

    task automatic send(input int gap);
        tgle_i = ~tgle_i;
        tick(gap);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulse"}, int'(evt_pulse_o), 0);
        chk({tag, "_valid"}, int'(evt_valid_o), 0);
        chk({tag, "_cnt"},   int'(evt_cnt_o),   0);
        chk({tag, "_ack"},   int'(ack_tgle_o),  0);
        chk({tag, "_ovf"},   int'(ovf_o),       0);
        chk({tag, "_total"}, int'(evt_total_o), 0);
    endtask

    initial begin
        rstn_i      = 1'b0;
        tgle_i      = 1'b0;
        evt_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rstn_i = 1'b1;
        tick(2);

        // T1 latency: toggle before edge 0, pulse after edge 2
        tgle_i = 1'b1;
        tick(1); chk("t1_pulse_e0", int'(evt_pulse_o), 0);
        tick(1); chk("t1_pulse_e1", int'(evt_pulse_o), 0);
                 chk("t1_cnt_e1",   int'(evt_cnt_o),   0);
        tick(1); chk("t1_pulse_e2", int'(evt_pulse_o), 1);
                 chk("t1_cnt_e2",   int'(evt_cnt_o),   1);
                 chk("t1_valid_e2", int'(evt_valid_o), 1);
                 chk("t1_ack_e2",   int'(ack_tgle_o),  0);
        tick(1); chk("t1_pulse_e3", int'(evt_pulse_o), 0);
                 chk("t1_cnt_e3",   int'(evt_cnt_o),   1);

        // T2 drain 3 events
        repeat (2) send(4);
        chk("t2_cnt_q", int'(evt_cnt_o), 3);
        evt_ready_i = 1'b1;
        tick(1); chk("t2_cnt_2", int'(evt_cnt_o), 2);
        tick(1); chk("t2_cnt_1", int'(evt_cnt_o), 1);
        tick(1); chk("t2_cnt_0", int'(evt_cnt_o), 0);
                 chk("t2_valid", int'(evt_valid_o), 0);
                 chk("t2_ack",   int'(ack_tgle_o), 1);
        tick(2); chk("t2_no_underflow", int'(evt_cnt_o), 0);
        evt_ready_i = 1'b0;

        // T3 fill to capacity and overflow
        for (int i = 0; i < 16; i++) begin
            send(4);
            if (i == 14) begin
                chk("t3_cnt_15th", int'(evt_cnt_o), 15);
                chk("t3_ovf_15th", int'(ovf_o), 0);
            end
        end
        chk("t3_cnt_full", int'(evt_cnt_o), 15);
        chk("t3_ovf_set",  int'(ovf_o), 1);
        ovf_clr_i = 1'b1; tick(1); ovf_clr_i = 1'b0;
        chk("t3_ovf_clr", int'(ovf_o), 0);
        // overflow set beats clear in the same cycle
        tgle_i = ~tgle_i;
        tick(2);
        ovf_clr_i = 1'b1; tick(1); ovf_clr_i = 1'b0;
        chk("t3_set_prio", int'(ovf_o), 1);
        chk("t3_cnt_hold", int'(evt_cnt_o), 15);
        ovf_clr_i = 1'b1; tick(1); ovf_clr_i = 1'b0;
        chk("t3_ovf_clr2", int'(ovf_o), 0);

        // T4 push and pop together while full
        tgle_i = ~tgle_i;
        tick(2);
        evt_ready_i = 1'b1; tick(1); evt_ready_i = 1'b0;
        chk("t4_pulse", int'(evt_pulse_o), 1);
        chk("t4_cnt",   int'(evt_cnt_o),   15);
        chk("t4_ovf",   int'(ovf_o),       0);
        chk("t4_ack",   int'(ack_tgle_o),  0);
        tick(2);

        // T5 reset in the middle of operation
        evt_ready_i = 1'b1; tick(11); evt_ready_i = 1'b0;
        chk("t5_cnt_4", int'(evt_cnt_o), 4);
        chk("t5_ack_1", int'(ack_tgle_o), 1);
        send(4);
        chk("t5_cnt_5", int'(evt_cnt_o), 5);
        chk("t5_ack",   int'(ack_tgle_o), 1);
        #3;
        rstn_i = 1'b0;
        tgle_i = 1'b0;
        #1;
        chk_all_zero("t5_async");
        tick(2);
        rstn_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t5_no_spurious", int'(evt_pulse_o), 0);
            chk("t5_cnt_zero",    int'(evt_cnt_o),   0);
        end

        // T6 statistics: 20 events, 2 consumed, 3 dropped
        evt_ready_i = 1'b1;
        repeat (2) send(4);
        evt_ready_i = 1'b0;
        repeat (18) send(4);
        chk("t6_cnt", int'(evt_cnt_o), 15);
        chk("t6_ovf", int'(ovf_o), 1);
        chk("t6_ack", int'(ack_tgle_o), 0);
`ifdef PULSE_SYNC_RX_STAT_EN
        chk("t6_total", int'(evt_total_o), 20);
`else
        chk("t6_total", int'(evt_total_o), 0);
`endif
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
